// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite constants, error-response state encoding and the
// transfer-size to byte-lane decoder used by the SRAM bridge.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Two-cycle ERROR response sequencing
    typedef enum logic [1:0] {
        ERR_OKAY = 2'd0,
        ERR_ERR1 = 2'd1,
        ERR_ERR2 = 2'd2
    } err_state_t;

    typedef struct packed {
        logic [3:0] lanes;
        logic       illegal;
    } lane_dec_t;

    // Byte lanes touched by a transfer; illegal transfers report no lanes
    function automatic lane_dec_t lane_decode(input logic [2:0] hsize,
                                              input logic [1:0] addr);
        lane_dec_t d;
        d.lanes   = 4'b0000;
        d.illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: d.lanes = 4'b0001 << addr;
            HSIZE_HALF: begin
                d.lanes   = addr[1] ? 4'b1100 : 4'b0011;
                d.illegal = addr[0];
            end
            HSIZE_WORD: begin
                d.lanes   = 4'b1111;
                d.illegal = (addr != 2'b00);
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.lanes = 4'b0000;
        end
        return d;
    endfunction

endpackage

// File: rtl/ahb_sram_bridge_sram_wbuf.sv
// One-entry posted write buffer: holds the pending write, drops it when
// the bridge grants a commit, and forwards its bytes over SRAM read data
// when a read targets the same word.
module sram_wbuf #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [3:0]    load_lanes,
    input  logic [31:0]   load_data,
    input  logic          commit,
    input  logic [AW-1:0] fwd_addr,
    input  logic [31:0]   rdata,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [3:0]    wb_lanes,
    output logic [31:0]   wb_data,
    output logic [31:0]   fwd_data
);

    logic hit;

    // Buffer registers: a new load takes priority over a same-cycle commit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_lanes <= 4'b0000;
            wb_data  <= 32'h0;
        end else if (load) begin
            wb_valid <= 1'b1;
            wb_addr  <= load_addr;
            wb_lanes <= load_lanes;
            wb_data  <= load_data;
        end else if (commit) begin
            wb_valid <= 1'b0;
        end
    end

    assign hit = wb_valid && (wb_addr == fwd_addr);

    // Byte-wise merge of buffered bytes over the SRAM read word
    always_comb begin
        fwd_data = rdata;
        for (int i = 0; i < 4; i++) begin
            if (hit && wb_lanes[i]) begin
                fwd_data[8*i +: 8] = wb_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave in front of a single-port synchronous SRAM. Reads use the
// port in their address phase; writes are posted into a one-entry buffer
// that drains whenever no read claims the port, giving zero wait states.
module ahb_sram_bridge
    import ahb_sram_pkg::*;
#(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic          HREADY,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          mem_ena,
    output logic [3:0]    mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    err_state_t    state, state_next;
    lane_dec_t     dec;
    logic          accept, rd_accept, wr_accept, err_accept;
    logic          rd_phase_q, wr_phase_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    lanes_q;
    logic          wb_load, wb_commit, wb_valid;
    logic [AW-1:0] wb_addr;
    logic [3:0]    wb_lanes;
    logic [31:0]   wb_data, fwd_data;
    logic          unused_bits;

    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    assign dec        = lane_decode(HSIZE, HADDR[1:0]);
    assign accept     = HSEL & HTRANS[1] & HREADY;
    assign rd_accept  = accept & ~HWRITE & ~dec.illegal;
    assign wr_accept  = accept &  HWRITE & ~dec.illegal;
    assign err_accept = accept &  dec.illegal;

    // Data-phase bookkeeping for the transfer accepted in the previous cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_phase_q <= 1'b0;
            wr_phase_q <= 1'b0;
            addr_q     <= '0;
            lanes_q    <= 4'b0000;
        end else if (HREADY) begin
            rd_phase_q <= rd_accept;
            wr_phase_q <= wr_accept;
            if (rd_accept || wr_accept) begin
                addr_q  <= HADDR[AW+1:2];
                lanes_q <= dec.lanes;
            end
        end
    end

    // Error response state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ERR_OKAY;
        end else begin
            state <= state_next;
        end
    end

    // Error response sequencing and bus handshake outputs
    always_comb begin
        state_next = state;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        case (state)
            ERR_OKAY: begin
                if (err_accept) begin
                    state_next = ERR_ERR1;
                end
            end
            ERR_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                state_next = ERR_ERR2;
            end
            ERR_ERR2: begin
                HRESP      = 1'b1;
                state_next = err_accept ? ERR_ERR1 : ERR_OKAY;
            end
            default: state_next = ERR_OKAY;
        endcase
    end

    assign wb_load   = wr_phase_q & HREADYOUT;
    assign wb_commit = resetn & wb_valid & ~rd_accept;

    sram_wbuf #(.AW(AW)) u_wbuf (
        .clk        (clk),
        .resetn     (resetn),
        .load       (wb_load),
        .load_addr  (addr_q),
        .load_lanes (lanes_q),
        .load_data  (HWDATA),
        .commit     (wb_commit),
        .fwd_addr   (addr_q),
        .rdata      (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_lanes   (wb_lanes),
        .wb_data    (wb_data),
        .fwd_data   (fwd_data)
    );

    // SRAM port arbitration: reads first, otherwise drain the buffer
    always_comb begin
        mem_ena  = 1'b0;
        mem_wen  = 4'b0000;
        mem_addr = wb_addr;
        if (resetn) begin
            if (rd_accept) begin
                mem_ena  = 1'b1;
                mem_addr = HADDR[AW+1:2];
            end else if (wb_valid) begin
                mem_ena = 1'b1;
                mem_wen = wb_lanes;
            end
        end
    end

    assign mem_wdata = wb_data;
    assign HRDATA    = rd_phase_q ? fwd_data : 32'h0;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Bench for ahb_sram_bridge: directed scenarios plus a random bus stream,
// checked against a byte-addressed view of memory and a commit scoreboard.
module tb_ahb_sram_bridge;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [2:0] S_BYTE   = 3'd0;
    localparam logic [2:0] S_HALF   = 3'd1;
    localparam logic [2:0] S_WORD   = 3'd2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        HSEL, HWRITE, HREADY;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA;
    logic        mem_ena;
    logic [3:0]  mem_wen;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    ahb_sram_bridge #(.AW(22)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .mem_ena   (mem_ena),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Power-on content of any SRAM word never written
    function automatic logic [31:0] init_word(input logic [21:0] wa);
        return {wa[15:0], ~wa[15:0]};
    endfunction

    // SRAM model: one access per enabled cycle, read data next cycle
    logic [31:0] sram [logic [21:0]];
    always @(posedge clk) begin : sram_model
        logic [31:0] w;
        if (mem_ena === 1'b1) begin
            w = sram.exists(mem_addr) ? sram[mem_addr] : init_word(mem_addr);
            if (mem_wen != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wen[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                sram[mem_addr] = w;
            end else begin
                mem_rdata <= w;
            end
        end
    end

    // Bus-visible memory contents
    logic [31:0] golden [logic [21:0]];

    function automatic logic bus_illegal(input logic [2:0] size, input logic [31:0] addr);
        int nbytes;
        if (size > 3'd2) return 1'b1;
        nbytes = 1 << size;
        return (int'(addr[1:0]) % nbytes) != 0;
    endfunction

    function automatic logic [3:0] bus_lanes(input logic [2:0] size, input logic [31:0] addr);
        logic [3:0] m;
        int lo, n;
        m  = 4'b0000;
        lo = int'(addr[1:0]);
        n  = 1 << size;
        for (int b = 0; b < 4; b++)
            if (b >= lo && b < lo + n) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] golden_rd(input logic [31:0] addr);
        logic [21:0] wa;
        wa = addr[23:2];
        return golden.exists(wa) ? golden[wa] : init_word(wa);
    endfunction

    task automatic golden_wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        logic [31:0] w;
        logic [3:0]  m;
        w = golden_rd(addr);
        m = bus_lanes(size, addr);
        for (int b = 0; b < 4; b++)
            if (m[b]) w[8*b +: 8] = data[8*b +: 8];
        golden[addr[23:2]] = w;
    endtask

    // Commit scoreboard: every completed bus write must reach the SRAM port
    // exactly once, in order, with at most one write outstanding
    typedef struct packed {
        logic [21:0] a;
        logic [3:0]  l;
        logic [31:0] d;
    } wr_t;
    wr_t         wq [$];
    logic        m_wr_pend = 1'b0;
    logic [31:0] m_wr_haddr;
    logic [2:0]  m_wr_size;

    always @(negedge clk) begin : commit_monitor
        wr_t  w;
        logic acc, ill;
        if (resetn !== 1'b1) begin
            checks++;
            if (mem_ena !== 1'b0 || mem_wen !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_port_idle: got ena=%b wen=%b expected ena=0 wen=0000", mem_ena, mem_wen);
            end
            wq.delete();
            m_wr_pend = 1'b0;
        end else begin
            if (mem_ena === 1'b1 && mem_wen !== 4'b0000) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL commit_unexpected: got wen=%b addr=%h expected no commit", mem_wen, mem_addr);
                end else begin
                    w = wq.pop_front();
                    if (mem_addr !== w.a || mem_wen !== w.l || mem_wdata !== w.d) begin
                        errors++;
                        $display("[TB] FAIL commit_content: got addr=%h wen=%b data=%h expected addr=%h wen=%b data=%h",
                                 mem_addr, mem_wen, mem_wdata, w.a, w.l, w.d);
                    end
                end
            end
            if (m_wr_pend) begin
                w.a = m_wr_haddr[23:2];
                w.l = bus_lanes(m_wr_size, m_wr_haddr);
                w.d = HWDATA;
                wq.push_back(w);
            end
            checks++;
            if (wq.size() > 1) begin
                errors++;
                $display("[TB] FAIL wbuf_no_stall: got %0d writes outstanding expected at most 1", wq.size());
                void'(wq.pop_front());
            end
            acc = HSEL & HTRANS[1] & HREADY;
            ill = bus_illegal(HSIZE, HADDR);
            if (acc && !ill && !HWRITE) begin
                checks++;
                if (mem_ena !== 1'b1 || mem_wen !== 4'b0000 || mem_addr !== HADDR[23:2]) begin
                    errors++;
                    $display("[TB] FAIL read_port: got ena=%b wen=%b addr=%h expected ena=1 wen=0000 addr=%h",
                             mem_ena, mem_wen, mem_addr, HADDR[23:2]);
                end
            end
            if (HREADY) begin
                m_wr_pend  = acc && !ill && HWRITE;
                m_wr_haddr = HADDR;
                m_wr_size  = HSIZE;
            end
        end
    end

    // Pipeline state kept by the bus driver
    logic        dp_read = 1'b0, dp_write = 1'b0;
    logic [31:0] dp_addr = 32'h0, dp_wdata = 32'h0;
    logic [2:0]  dp_size = 3'd0;
    int          err_stage = 0;
    logic        hist1 = 1'b0, hist2 = 1'b0;

    // Observed and expected values for the most recent cycle
    logic        obs_ready, obs_resp, obs_ena;
    logic [31:0] obs_rdata, obs_wdata;
    logic [3:0]  obs_wen;
    logic [21:0] obs_addr;
    logic        exp_ready, exp_resp;
    logic [31:0] exp_rdata;

    // Drive one bus cycle starting just after a rising edge
    task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        logic acc, ill, rst_now;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
        HREADY = (err_stage != 1);
        HWDATA = dp_write ? dp_wdata : $urandom();
        @(negedge clk);
        exp_ready = (err_stage != 1);
        exp_resp  = (err_stage != 0);
        exp_rdata = dp_read ? golden_rd(dp_addr) : 32'h0;
        obs_ready = HREADYOUT;
        obs_resp  = HRESP;
        obs_rdata = HRDATA;
        obs_ena   = mem_ena;
        obs_wen   = mem_wen;
        obs_addr  = mem_addr;
        obs_wdata = mem_wdata;
        rst_now   = !resetn;
        if (dp_write && !rst_now) golden_wr(dp_addr, dp_size, dp_wdata);
        acc = sel & trans[1] & HREADY;
        ill = bus_illegal(size, addr);
        @(posedge clk);
        #1;
        if (rst_now) begin
            dp_read   = 1'b0;
            dp_write  = 1'b0;
            err_stage = 0;
            hist1     = 1'b0;
            hist2     = 1'b0;
        end else begin
            err_stage = (err_stage == 1) ? 2 : ((acc && ill) ? 1 : 0);
            if (HREADY) begin
                dp_read  = acc && !ill && !wr;
                dp_write = acc && !ill && wr;
                dp_addr  = addr;
                dp_size  = size;
                dp_wdata = wdata;
            end
            hist2 = hist1;
            hist1 = HREADY && acc && !ill && wr;
        end
    endtask

    task automatic idle_cycle();
        step(1'b1, T_IDLE, 1'b0, 32'h0, S_WORD, 32'h0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        HSEL = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0; HADDR = 32'h0;
        HSIZE = S_WORD; HREADY = 1'b1; HWDATA = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (HREADYOUT !== 1'b1) begin errors++; $display("[TB] FAIL reset_hreadyout: got %b expected 1", HREADYOUT); end
        checks++;
        if (HRESP !== 1'b0) begin errors++; $display("[TB] FAIL reset_hresp: got %b expected 0", HRESP); end
        checks++;
        if (HRDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_hrdata: got %h expected 0", HRDATA); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_word_write();
        step(1'b1, T_NONSEQ, 1'b1, 32'h10, S_WORD, 32'hDEADBEEF);
        idle_cycle();
        idle_cycle();
        checks++;
        if (obs_ena !== 1'b1 || obs_wen !== 4'b1111) begin
            errors++; $display("[TB] FAIL word_commit_strobe: got ena=%b wen=%b expected ena=1 wen=1111", obs_ena, obs_wen);
        end
        checks++;
        if (obs_addr !== 22'h4 || obs_wdata !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL word_commit_data: got addr=%h data=%h expected addr=4 data=deadbeef", obs_addr, obs_wdata);
        end
        step(1'b1, T_NONSEQ, 1'b0, 32'h10, S_WORD, 32'h0);
        idle_cycle();
        checks++;
        if (obs_rdata !== 32'hDEADBEEF || obs_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL word_readback: got data=%h ready=%b expected data=deadbeef ready=1", obs_rdata, obs_ready);
        end
    endtask

    task automatic test_forward();
        sram[22'h4]   = 32'h11223344;
        golden[22'h4] = 32'h11223344;
        step(1'b1, T_NONSEQ, 1'b1, 32'h13, S_BYTE, 32'hAB000000);
        step(1'b1, T_NONSEQ, 1'b0, 32'h10, S_WORD, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, T_NONSEQ, 1'b0, 32'h10, S_WORD, 32'h0);
            checks++;
            if (obs_rdata !== 32'hAB223344) begin
                errors++; $display("[TB] FAIL forward_data: got %h expected ab223344", obs_rdata);
            end
            checks++;
            if (obs_wen !== 4'b0000) begin
                errors++; $display("[TB] FAIL forward_no_commit: got wen=%b expected 0000", obs_wen);
            end
        end
        step(1'b1, T_NONSEQ, 1'b1, 32'h40, S_WORD, 32'h01020304);
        checks++;
        if (obs_rdata !== 32'hAB223344) begin
            errors++; $display("[TB] FAIL forward_last_read: got %h expected ab223344", obs_rdata);
        end
        checks++;
        if (obs_ena !== 1'b1 || obs_wen !== 4'b1000 || obs_addr !== 22'h4 || obs_wdata !== 32'hAB000000) begin
            errors++; $display("[TB] FAIL forward_commit: got ena=%b wen=%b addr=%h data=%h expected ena=1 wen=1000 addr=4 data=ab000000",
                               obs_ena, obs_wen, obs_addr, obs_wdata);
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_half();
        step(1'b1, T_NONSEQ, 1'b1, 32'h20, S_HALF, 32'h00005566);
        step(1'b1, T_NONSEQ, 1'b1, 32'h22, S_HALF, 32'h77880000);
        idle_cycle();
        checks++;
        if (obs_wen !== 4'b0011 || obs_addr !== 22'h8 || obs_wdata !== 32'h00005566) begin
            errors++; $display("[TB] FAIL half_commit_lo: got wen=%b addr=%h data=%h expected wen=0011 addr=8 data=00005566",
                               obs_wen, obs_addr, obs_wdata);
        end
        idle_cycle();
        checks++;
        if (obs_wen !== 4'b1100 || obs_addr !== 22'h8 || obs_wdata !== 32'h77880000) begin
            errors++; $display("[TB] FAIL half_commit_hi: got wen=%b addr=%h data=%h expected wen=1100 addr=8 data=77880000",
                               obs_wen, obs_addr, obs_wdata);
        end
        step(1'b1, T_NONSEQ, 1'b0, 32'h20, S_WORD, 32'h0);
        idle_cycle();
        checks++;
        if (obs_rdata !== 32'h77885566) begin
            errors++; $display("[TB] FAIL half_readback: got %h expected 77885566", obs_rdata);
        end
    endtask

    task automatic test_error();
        step(1'b1, T_NONSEQ, 1'b0, 32'h102, S_WORD, 32'h0);
        checks++;
        if (obs_ena !== 1'b0 || obs_ready !== 1'b1 || obs_resp !== 1'b0) begin
            errors++; $display("[TB] FAIL err_addr_phase: got ena=%b ready=%b resp=%b expected ena=0 ready=1 resp=0",
                               obs_ena, obs_ready, obs_resp);
        end
        idle_cycle();
        checks++;
        if (obs_ready !== 1'b0 || obs_resp !== 1'b1 || obs_ena !== 1'b0) begin
            errors++; $display("[TB] FAIL err_first_cycle: got ready=%b resp=%b ena=%b expected ready=0 resp=1 ena=0",
                               obs_ready, obs_resp, obs_ena);
        end
        idle_cycle();
        checks++;
        if (obs_ready !== 1'b1 || obs_resp !== 1'b1 || obs_ena !== 1'b0) begin
            errors++; $display("[TB] FAIL err_second_cycle: got ready=%b resp=%b ena=%b expected ready=1 resp=1 ena=0",
                               obs_ready, obs_resp, obs_ena);
        end
        idle_cycle();
        checks++;
        if (obs_ready !== 1'b1 || obs_resp !== 1'b0) begin
            errors++; $display("[TB] FAIL err_recovered: got ready=%b resp=%b expected ready=1 resp=0", obs_ready, obs_resp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        d1 = $urandom();
        d2 = $urandom();
        step(1'b1, T_NONSEQ, 1'b1, 32'h30, S_WORD, d1);
        step(1'b1, T_NONSEQ, 1'b0, 32'h30, S_WORD, 32'h0);
        checks++;
        if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_r1: got %b expected 1", obs_ready); end
        step(1'b1, T_NONSEQ, 1'b1, 32'h34, S_WORD, d2);
        checks++;
        if (obs_rdata !== d1 || obs_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_read1: got data=%h ready=%b expected data=%h ready=1", obs_rdata, obs_ready, d1);
        end
        step(1'b1, T_NONSEQ, 1'b0, 32'h34, S_WORD, 32'h0);
        checks++;
        if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_r2: got %b expected 1", obs_ready); end
        idle_cycle();
        checks++;
        if (obs_rdata !== d2 || obs_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_read2: got data=%h ready=%b expected data=%h ready=1", obs_rdata, obs_ready, d2);
        end
        idle_cycle();
    endtask

    task automatic test_reset_discard();
        logic [31:0] old;
        old = golden_rd(32'h60);
        step(1'b1, T_NONSEQ, 1'b1, 32'h60, S_WORD, 32'hCAFEF00D);
        idle_cycle();
        resetn = 1'b0;
        idle_cycle();
        resetn = 1'b1;
        golden[22'h18] = old;
        checks++;
        if (obs_ena !== 1'b0) begin errors++; $display("[TB] FAIL discard_no_write: got ena=%b expected 0", obs_ena); end
        idle_cycle();
        checks++;
        if (obs_ready !== 1'b1 || obs_resp !== 1'b0 || obs_ena !== 1'b0) begin
            errors++; $display("[TB] FAIL discard_after: got ready=%b resp=%b ena=%b expected ready=1 resp=0 ena=0",
                               obs_ready, obs_resp, obs_ena);
        end
        step(1'b1, T_NONSEQ, 1'b0, 32'h60, S_WORD, 32'h0);
        idle_cycle();
        checks++;
        if (obs_rdata !== old) begin errors++; $display("[TB] FAIL discard_readback: got %h expected %h", obs_rdata, old); end
    endtask

    task automatic test_random();
        logic        sel, wr;
        logic [1:0]  tr;
        logic [2:0]  size;
        logic [31:0] addr;
        for (int i = 0; i < 400; i++) begin
            sel  = ($urandom_range(0, 7) != 0);
            tr   = 2'($urandom_range(0, 3));
            wr   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            addr = 32'h100 + 32'($urandom_range(0, 15));
            if (size <= 3'd2 && $urandom_range(0, 4) != 0)
                addr = addr & ~((32'd1 << size) - 32'd1);
            if (hist1 && hist2 && !wr) tr = T_IDLE;
            step(sel, tr, wr, addr, size, $urandom());
            checks++;
            if (obs_ready !== exp_ready || obs_resp !== exp_resp) begin
                errors++; $display("[TB] FAIL rand_resp[%0d]: got ready=%b resp=%b expected ready=%b resp=%b",
                                   i, obs_ready, obs_resp, exp_ready, exp_resp);
            end
            checks++;
            if (obs_rdata !== exp_rdata) begin
                errors++; $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", i, obs_rdata, exp_rdata);
            end
        end
        repeat (4) idle_cycle();
        checks++;
        if (wq.size() != 0) begin
            errors++; $display("[TB] FAIL rand_drain: got %0d writes outstanding expected 0", wq.size());
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_word_write();
        test_forward();
        test_half();
        test_error();
        test_back_to_back();
        test_reset_discard();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
